// File: rtl/timing_test_stim_chk.sv
// LFSR stimulus driver and response checker for the timing_test netlist (out1 = 2-cycle AND, out2 = wire).
// Latency: vector k drives in1..in3 during busy cycle k; results settle the cycle done rises; start ignored while busy.
module timing_test_stim_chk #(
  parameter int          NUM_VECTORS = 256,
  parameter int          VCW         = 16,
  parameter int          ERRW        = 8,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            out1_i,
  input  logic            out2_i,
  output logic            in1_o,
  output logic            in2_o,
  output logic            in3_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [ERRW-1:0] err_count_o,
  output logic [VCW-1:0]  first_err_idx_o
);

  localparam logic [15:0]    SEED_EFF   = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic [VCW-1:0] LAST_RUN   = VCW'(NUM_VECTORS - 1);
  localparam logic [VCW-1:0] LAST_DRAIN = VCW'(NUM_VECTORS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d, lfsr_nxt;
  logic [2:0]      in_q, in_d;
  logic [VCW-1:0]  vec_q, vec_d;
  logic [ERRW-1:0] err_q, err_d;
  logic [VCW-1:0]  first_q, first_d;
  logic            e1_q, e1_d, e1_vld_q, e1_vld_d;
  logic            e2_q, e2_d, e2_vld_q, e2_vld_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            launch, mis1, mis2;
  logic [ERRW:0]   err_sum;

  assign lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // vec_q keeps counting through DRAIN, so vec_q-2 is the vector whose out1 is due now
  assign mis1    = ((state_q == RUN) || (state_q == DRAIN)) && e2_vld_q && (out1_i != e2_q);
  assign mis2    = (state_q == RUN) && (out2_i != in_q[2]);
  assign err_sum = {1'b0, err_q} + (ERRW+1)'(mis1) + (ERRW+1)'(mis2);

  always_comb begin
    state_d  = state_q;
    launch   = 1'b0;
    lfsr_d   = lfsr_q;
    in_d     = 3'b000;
    vec_d    = vec_q;
    err_d    = err_q;
    first_d  = first_q;
    e1_d     = in_q[0] & in_q[1];
    e1_vld_d = (state_q == RUN);
    e2_d     = e1_q;
    e2_vld_d = e1_vld_q;

    case (state_q)
      IDLE, DONE: if (start_i) begin
        state_d = RUN;
        launch  = 1'b1;
      end
      RUN:     if (vec_q == LAST_RUN) state_d = DRAIN;
      DRAIN:   if (vec_q == LAST_DRAIN) state_d = DONE;
      default: state_d = IDLE;
    endcase

    if (launch) begin
      lfsr_d   = SEED_EFF;
      in_d     = SEED_EFF[2:0];
      vec_d    = '0;
      err_d    = '0;
      first_d  = '1;
      e1_vld_d = 1'b0;
      e2_vld_d = 1'b0;
    end else begin
      if (state_q == RUN) begin
        lfsr_d = lfsr_nxt;
        if (state_d == RUN) in_d = lfsr_nxt[2:0];
      end
      if ((state_q == RUN) || (state_q == DRAIN)) vec_d = vec_q + 1'b1;
      if (err_sum > {1'b0, {ERRW{1'b1}}}) err_d = '1;
      else                                err_d = err_sum[ERRW-1:0];
      // out1's vector index is always the lower one when both miss
      if (first_q == '1) begin
        if (mis1)      first_d = vec_q - VCW'(2);
        else if (mis2) first_d = vec_q;
      end
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED_EFF;
      in_q     <= 3'b000;
      vec_q    <= '0;
      err_q    <= '0;
      first_q  <= '1;
      e1_q     <= 1'b0;
      e1_vld_q <= 1'b0;
      e2_q     <= 1'b0;
      e2_vld_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      in_q     <= in_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
      first_q  <= first_d;
      e1_q     <= e1_d;
      e1_vld_q <= e1_vld_d;
      e2_q     <= e2_d;
      e2_vld_q <= e2_vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign in1_o           = in_q[0];
  assign in2_o           = in_q[1];
  assign in3_o           = in_q[2];
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = done_q & (err_q == '0);
  assign err_count_o     = err_q;
  assign first_err_idx_o = first_q;

endmodule

// File: tb/tb_timing_test_stim_chk.sv
// Bench: two checker instances looped through a behavioural timing_test model with fault injection;
// a reference LFSR fills vector/result queues at each start, drained as the checker runs.
module tb_timing_test_stim_chk;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] err;
    logic [31:0] first;
    logic [31:0] pass;
    logic [31:0] cycles;
  } res_t;

  logic [2:0] vec_qa[$];
  res_t       res_qa[$];
  res_t       res_qb[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Instance A: 8 vectors, 8-bit error counter
  logic a_start = 1'b0, a_zero2 = 1'b0;
  logic a_out1, a_out2, a_in1, a_in2, a_in3, a_busy, a_done, a_pass, a_p1, a_p2;
  logic [7:0]  a_err;
  logic [15:0] a_first;
  always @(posedge clk) begin
    a_p1 <= a_in1 & a_in2;
    a_p2 <= a_p1;
  end
  assign a_out1 = a_p2;
  assign a_out2 = a_zero2 ? 1'b0 : a_in3;

  timing_test_stim_chk #(.NUM_VECTORS(8), .VCW(16), .ERRW(8), .SEED(16'hACE1)) u_a (
    .clk_i(clk), .rst_i(rst), .start_i(a_start), .out1_i(a_out1), .out2_i(a_out2),
    .in1_o(a_in1), .in2_o(a_in2), .in3_o(a_in3), .busy_o(a_busy), .done_o(a_done),
    .pass_o(a_pass), .err_count_o(a_err), .first_err_idx_o(a_first)
  );

  // Instance B: 6 vectors, 2-bit saturating error counter
  logic b_start = 1'b0, b_inj1 = 1'b0, b_inv1 = 1'b0, b_inv2 = 1'b0;
  logic b_out1, b_out2, b_in1, b_in2, b_in3, b_busy, b_done, b_pass, b_p1, b_p2;
  logic [1:0]  b_err;
  logic [15:0] b_first;
  int          b_cyc = 0;
  always @(posedge clk) begin
    b_p1  <= b_in1 & b_in2;
    b_p2  <= b_p1;
    b_cyc <= b_busy ? b_cyc + 1 : 0;
  end
  // busy cycle 7 is the second drain cycle, where vector 5's out1 is checked
  assign b_out1 = b_p2 ^ b_inv1 ^ (b_inj1 && (b_cyc == 7));
  assign b_out2 = b_in3 ^ b_inv2;

  timing_test_stim_chk #(.NUM_VECTORS(6), .VCW(16), .ERRW(2), .SEED(16'hACE1)) u_b (
    .clk_i(clk), .rst_i(rst), .start_i(b_start), .out1_i(b_out1), .out2_i(b_out2),
    .in1_o(b_in1), .in2_o(b_in2), .in3_o(b_in3), .busy_o(b_busy), .done_o(b_done),
    .pass_o(b_pass), .err_count_o(b_err), .first_err_idx_o(b_first)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference run for instance A: vectors from the LFSR, errors only from out2 tied low
  task automatic expect_a(input bit zero2);
    logic [15:0] l;
    res_t        r;
    l       = 16'hACE1;
    r.err   = 0;
    r.first = 32'h0000_FFFF;
    for (int k = 0; k < 8; k++) begin
      vec_qa.push_back(l[2:0]);
      if (zero2 && l[2]) begin
        r.err = r.err + 1;
        if (r.first == 32'h0000_FFFF) r.first = k;
      end
      l = lfsr_next(l);
    end
    r.pass   = (r.err == 0) ? 32'd1 : 32'd0;
    r.cycles = 10;
    res_qa.push_back(r);
  endtask

  task automatic start_a();
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
  endtask

  task automatic start_b();
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
  endtask

  task automatic pop_vec_a(input string tag);
    logic [2:0] v;
    check({tag, "_vq_nonempty"}, (vec_qa.size() != 0), 1);
    if (vec_qa.size() != 0) begin
      v = vec_qa.pop_front();
      check({tag, "_vec"}, {a_in3, a_in2, a_in1}, v);
    end
  endtask

  // Called at the falling edge of RUN cycle 0; optionally pulses start at busy cycle pulse_at
  task automatic watch_a(input string tag, input int pulse_at);
    int   cyc;
    res_t r;
    cyc = 0;
    while (a_busy === 1'b1 && cyc < 100) begin
      a_start = (cyc == pulse_at);
      if (cyc < 8) pop_vec_a(tag);
      else         check({tag, "_drain_in"}, {a_in3, a_in2, a_in1}, 3'b000);
      check({tag, "_pass_low_busy"}, a_pass, 1'b0);
      cyc++;
      @(negedge clk);
    end
    a_start = 1'b0;
    check({tag, "_rq_nonempty"}, (res_qa.size() != 0), 1);
    if (res_qa.size() != 0) begin
      r = res_qa.pop_front();
      check({tag, "_busy_cycles"}, cyc, r.cycles);
      check({tag, "_done"}, a_done, 1'b1);
      check({tag, "_err"}, a_err, r.err);
      check({tag, "_first"}, a_first, r.first);
      check({tag, "_pass"}, a_pass, r.pass);
    end
  endtask

  task automatic watch_b(input string tag);
    int   cyc;
    res_t r;
    cyc = 0;
    while (b_busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_rq_nonempty"}, (res_qb.size() != 0), 1);
    if (res_qb.size() != 0) begin
      r = res_qb.pop_front();
      check({tag, "_busy_cycles"}, cyc, r.cycles);
      check({tag, "_done"}, b_done, 1'b1);
      check({tag, "_err"}, b_err, r.err);
      check({tag, "_first"}, b_first, r.first);
      check({tag, "_pass"}, b_pass, r.pass);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_a_in", {a_in3, a_in2, a_in1}, 3'b000);
    check("rst_a_flags", {a_busy, a_done, a_pass}, 3'b000);
    check("rst_a_err", a_err, 0);
    check("rst_a_first", a_first, 16'hFFFF);
    check("rst_b_flags", {b_busy, b_done, b_pass}, 3'b000);
    check("rst_b_first", b_first, 16'hFFFF);
    rst = 1'b0;

    // 1: ideal loopback
    expect_a(1'b0);
    start_a();
    watch_a("t1", -1);

    // 2: out2 stuck low
    a_zero2 = 1'b1;
    expect_a(1'b1);
    start_a();
    watch_a("t2", -1);
    a_zero2 = 1'b0;

    // 3: single out1 miss on vector 5, seen in the second drain cycle
    b_inj1 = 1'b1;
    res_qb.push_back('{32'd1, 32'd5, 32'd0, 32'd8});
    start_b();
    watch_b("t3");
    b_inj1 = 1'b0;

    // 4: both outputs inverted, 2-bit counter saturates
    b_inv1 = 1'b1;
    b_inv2 = 1'b1;
    res_qb.push_back('{32'd3, 32'd0, 32'd0, 32'd8});
    start_b();
    watch_b("t4");
    b_inv1 = 1'b0;
    b_inv2 = 1'b0;

    // 5: reset in RUN cycle 4 with errors already counted, then rerun
    a_zero2 = 1'b1;
    expect_a(1'b1);
    start_a();
    for (int k = 0; k < 4; k++) begin
      pop_vec_a("t5_pre");
      @(negedge clk);
    end
    check("t5_busy_before", a_busy, 1'b1);
    check("t5_err_before", a_err, 8'd2);
    rst = 1'b1;
    #1;
    check("t5_rst_in", {a_in3, a_in2, a_in1}, 3'b000);
    check("t5_rst_flags", {a_busy, a_done, a_pass}, 3'b000);
    check("t5_rst_err", a_err, 0);
    check("t5_rst_first", a_first, 16'hFFFF);
    vec_qa.delete();
    res_qa.delete();
    @(negedge clk) rst = 1'b0;
    a_zero2 = 1'b0;
    expect_a(1'b0);
    start_a();
    watch_a("t5_rerun", -1);

    // 6: start pulse in RUN cycle 3 ignored; start in DONE restarts
    expect_a(1'b0);
    start_a();
    watch_a("t6", 3);
    expect_a(1'b0);
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    check("t6_done_cleared", a_done, 1'b0);
    check("t6_busy_restart", a_busy, 1'b1);
    watch_a("t6_restart", -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
